// File: rtl/hssi_ss_rst_pkg.sv
// Shared definitions for the HSSI port reset sequencer: state encodings,
// error bit positions and the state-to-output decode.
package hssi_ss_rst_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_ASSERT = 3'd1;
  localparam state_t ST_ACKED  = 3'd2;
  localparam state_t ST_REL_TX = 3'd3;
  localparam state_t ST_REL_RX = 3'd4;

  localparam int ERR_ASSERT = 0;
  localparam int ERR_REL_TX = 1;
  localparam int ERR_REL_RX = 2;

  // Returns {ack, rx_rst, tx_rst}; unused encodings decode like ASSERT.
  function automatic logic [2:0] out_decode(input state_t s);
    case (s)
      ST_IDLE:   out_decode = 3'b000;
      ST_ASSERT: out_decode = 3'b011;
      ST_ACKED:  out_decode = 3'b111;
      ST_REL_TX: out_decode = 3'b110;
      ST_REL_RX: out_decode = 3'b100;
      default:   out_decode = 3'b011;
    endcase
  endfunction

endpackage

// File: rtl/hssi_bit_sync.sv
// Single-bit synchronizer: STAGES-deep flop chain for an asynchronous level.
module hssi_bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic d,
  output logic q
);

  // NOTE: the chain carries no reset; it only ever holds a delayed copy of d
  // and a reset would just add a reset path into the metastability flops.
  (* async_reg = "true" *) logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    sync_q <= {sync_q[STAGES-2:0], d};
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/hssi_port_rst_seq.sv
// Sequences TX/RX resets of one HSSI port against a level request/ack
// handshake, with per-wait timeouts and sticky error flags.
module hssi_port_rst_seq
  import hssi_ss_rst_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_req,
  output logic       o_ack,
  output logic       o_tx_rst,
  output logic       o_rx_rst,
  input  logic       i_tx_rst_ack,
  input  logic       i_rx_rst_ack,
  input  logic       i_tx_ready,
  input  logic       i_rx_ready,
  output logic [2:0] o_err,
  output logic [2:0] o_state
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  logic       tx_ack_s, rx_ack_s, tx_rdy_s, rx_rdy_s;
  state_t     state, next_state;
  logic [CNT_W-1:0] cnt;
  logic       timeout;
  logic [2:0] err_set;

  hssi_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_tx_ack (.clk(i_clk), .d(i_tx_rst_ack), .q(tx_ack_s));
  hssi_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rx_ack (.clk(i_clk), .d(i_rx_rst_ack), .q(rx_ack_s));
  hssi_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_tx_rdy (.clk(i_clk), .d(i_tx_ready),   .q(tx_rdy_s));
  hssi_bit_sync #(.STAGES(SYNC_STAGES)) u_sync_rx_rdy (.clk(i_clk), .d(i_rx_ready),   .q(rx_rdy_s));

  assign timeout = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // NOTE: every output of this block gets a default first so no path leaves
  // a value unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = ST_ASSERT;
    err_set    = '0;
    case (state)
      ST_IDLE:   next_state = i_req ? ST_ASSERT : ST_IDLE;
      ST_ASSERT: begin
        if (tx_ack_s && rx_ack_s) begin
          next_state = ST_ACKED;
        end else if (timeout) begin
          next_state          = ST_ACKED;
          err_set[ERR_ASSERT] = 1'b1;
        end else begin
          next_state = ST_ASSERT;
        end
      end
      ST_ACKED:  next_state = i_req ? ST_ACKED : ST_REL_TX;
      // The release runs to completion even if i_req rises again meanwhile.
      ST_REL_TX: begin
        if (!tx_ack_s && tx_rdy_s) begin
          next_state = ST_REL_RX;
        end else if (timeout) begin
          next_state          = ST_REL_RX;
          err_set[ERR_REL_TX] = 1'b1;
        end else begin
          next_state = ST_REL_TX;
        end
      end
      ST_REL_RX: begin
        if (!rx_ack_s && rx_rdy_s) begin
          next_state = ST_IDLE;
        end else if (timeout) begin
          next_state          = ST_IDLE;
          err_set[ERR_REL_RX] = 1'b1;
        end else begin
          next_state = ST_REL_RX;
        end
      end
      default:   next_state = ST_ASSERT;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= ST_ASSERT;
      cnt      <= '0;
      o_err    <= '0;
      o_tx_rst <= 1'b1;
      o_rx_rst <= 1'b1;
      o_ack    <= 1'b0;
    end else begin
      state <= next_state;
      o_err <= o_err | err_set;
      {o_ack, o_rx_rst, o_tx_rst} <= out_decode(next_state);
      if (next_state != state) begin
        cnt <= '0;
      end else if (state == ST_ASSERT || state == ST_REL_TX || state == ST_REL_RX) begin
        cnt <= cnt + 1'b1;
      end else begin
        cnt <= '0;
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_hssi_port_rst_seq.sv
// Directed bench for hssi_port_rst_seq with SYNC_STAGES=2, TIMEOUT_CYC=16;
// IP status inputs are driven by hand with cycle-exact expectations.
module tb_hssi_port_rst_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       ack, tx_rst, rx_rst;
  logic       tx_rst_ack, rx_rst_ack, tx_ready, rx_ready;
  logic [2:0] err, state;

  int n_checks = 0;
  int n_errors = 0;

  hssi_port_rst_seq #(.SYNC_STAGES(2), .TIMEOUT_CYC(16)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req        (req),
    .o_ack        (ack),
    .o_tx_rst     (tx_rst),
    .o_rx_rst     (rx_rst),
    .i_tx_rst_ack (tx_rst_ack),
    .i_rx_rst_ack (rx_rst_ack),
    .i_tx_ready   (tx_ready),
    .i_rx_ready   (rx_ready),
    .o_err        (err),
    .o_state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_out(input string tag, input int st, input logic t, input logic r,
                           input logic a);
    check({tag, ".state"},  32'(state),  32'(st));
    check({tag, ".tx_rst"}, 32'(tx_rst), 32'(t));
    check({tag, ".rx_rst"}, 32'(rx_rst), 32'(r));
    check({tag, ".ack"},    32'(ack),    32'(a));
  endtask

  // Advance n rising edges; sample 1 time unit after the last one.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 1'b0;
    tx_rst_ack = 1'b0; rx_rst_ack = 1'b0; tx_ready = 1'b0; rx_ready = 1'b0;

    // Power-up: reset lands in ASSERT, then a full handshake with i_req low.
    tick(3);
    check_out("rst", 1, 1'b1, 1'b1, 1'b0);
    check("rst.err", 32'(err), 32'd0);
    rst = 1'b0; tx_rst_ack = 1'b1; rx_rst_ack = 1'b1;
    tick(2);
    check_out("pu.wait_ack", 1, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_out("pu.acked", 2, 1'b1, 1'b1, 1'b1);
    tick(1);
    check_out("pu.rel_tx", 3, 1'b0, 1'b1, 1'b1);
    tx_rst_ack = 1'b0; tx_ready = 1'b1;
    tick(2);
    check_out("pu.rel_tx_hold", 3, 1'b0, 1'b1, 1'b1);
    tick(1);
    check_out("pu.rel_rx", 4, 1'b0, 1'b0, 1'b1);
    rx_rst_ack = 1'b0; rx_ready = 1'b1;
    tick(2);
    check_out("pu.rel_rx_hold", 4, 1'b0, 1'b0, 1'b1);
    tick(1);
    check_out("pu.idle", 0, 1'b0, 1'b0, 1'b0);
    check("pu.err", 32'(err), 32'd0);

    // Normal cycle: acks arrive 3 cycles after request, ack at +6.
    req = 1'b1;
    tick(1);
    check_out("nc.assert", 1, 1'b1, 1'b1, 1'b0);
    tick(2);
    tx_rst_ack = 1'b1; rx_rst_ack = 1'b1; tx_ready = 1'b0; rx_ready = 1'b0;
    tick(2);
    check_out("nc.wait_ack", 1, 1'b1, 1'b1, 1'b0);
    tick(1);
    check_out("nc.acked", 2, 1'b1, 1'b1, 1'b1);
    tick(2);
    check_out("nc.acked_hold", 2, 1'b1, 1'b1, 1'b1);
    req = 1'b0;
    tick(1);
    check_out("nc.rel_tx", 3, 1'b0, 1'b1, 1'b1);
    tx_rst_ack = 1'b0; tx_ready = 1'b1;
    tick(2);
    check_out("nc.rel_tx_hold", 3, 1'b0, 1'b1, 1'b1);
    tick(1);
    check_out("nc.rel_rx", 4, 1'b0, 1'b0, 1'b1);
    rx_rst_ack = 1'b0; rx_ready = 1'b1;
    tick(2);
    check_out("nc.rel_rx_hold", 4, 1'b0, 1'b0, 1'b1);
    tick(1);
    check_out("nc.idle", 0, 1'b0, 1'b0, 1'b0);

    // IP silent: every wait state times out after exactly 16 cycles.
    tx_ready = 1'b0; rx_ready = 1'b0;
    tick(3);
    check_out("to.idle_hold", 0, 1'b0, 1'b0, 1'b0);
    req = 1'b1;
    tick(1);
    check_out("to.assert", 1, 1'b1, 1'b1, 1'b0);
    tick(15);
    check_out("to.assert_15", 1, 1'b1, 1'b1, 1'b0);
    check("to.err_pre", 32'(err), 32'd0);
    tick(1);
    check_out("to.acked_16", 2, 1'b1, 1'b1, 1'b1);
    check("to.err_assert", 32'(err), 32'b001);
    req = 1'b0;
    tick(1);
    check_out("to.rel_tx", 3, 1'b0, 1'b1, 1'b1);
    tick(15);
    check_out("to.rel_tx_15", 3, 1'b0, 1'b1, 1'b1);
    tick(1);
    check_out("to.rel_rx", 4, 1'b0, 1'b0, 1'b1);
    check("to.err_tx", 32'(err), 32'b011);
    tick(15);
    check("to.rel_rx_15", 32'(state), 32'd4);
    tick(1);
    check_out("to.idle", 0, 1'b0, 1'b0, 1'b0);
    check("to.err_all", 32'(err), 32'b111);

    // Reset in REL_RX: back to ASSERT, errors cleared.
    req = 1'b1; tx_rst_ack = 1'b1; rx_rst_ack = 1'b1;
    tick(1);
    check_out("mr.assert", 1, 1'b1, 1'b1, 1'b0);
    tick(2);
    check_out("mr.acked", 2, 1'b1, 1'b1, 1'b1);
    check("mr.err_sticky", 32'(err), 32'b111);
    req = 1'b0;
    tick(1);
    tx_rst_ack = 1'b0; tx_ready = 1'b1;
    tick(3);
    check_out("mr.rel_rx", 4, 1'b0, 1'b0, 1'b1);
    rst = 1'b1;
    tick(1);
    check_out("mr.reset", 1, 1'b1, 1'b1, 1'b0);
    check("mr.err_clr", 32'(err), 32'd0);
    rst = 1'b0; tx_rst_ack = 1'b1; tx_ready = 1'b0;
    tick(2);
    check("mr.wait_ack", 32'(state), 32'd1);
    tick(1);
    check_out("mr.reacked", 2, 1'b1, 1'b1, 1'b1);

    // Early re-request during REL_TX: release completes, IDLE for one cycle.
    tick(1);
    check_out("er.rel_tx", 3, 1'b0, 1'b1, 1'b1);
    req = 1'b1; tx_rst_ack = 1'b0; tx_ready = 1'b1;
    tick(2);
    check_out("er.rel_tx_hold", 3, 1'b0, 1'b1, 1'b1);
    tick(1);
    check_out("er.rel_rx", 4, 1'b0, 1'b0, 1'b1);
    rx_rst_ack = 1'b0; rx_ready = 1'b1;
    tick(3);
    check_out("er.idle", 0, 1'b0, 1'b0, 1'b0);
    tick(1);
    check_out("er.reassert", 1, 1'b1, 1'b1, 1'b0);
    check("er.err", 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
